// File: rtl/spiram_arb_pkg.sv
// spiram_arb_pkg: FSM states, Wishbone cycle-type codes and one-hot grant encodings
// shared by the spiram Wishbone arbiter and its round-robin picker.
package spiram_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
  function automatic logic [1:0] state_grant(input state_t s);
    return s == OWN0 ? GNT_M0 : s == OWN1 ? GNT_M1 : GNT_NONE;
  endfunction
endpackage

// File: rtl/spiram_arb_rr.sv
// spiram_arb_rr: 2-way round-robin picker; on a tie the master that did not own last wins.
module spiram_arb_rr
  import spiram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] win
);
  always_comb win = req == 2'b11 ? (last_owner ? GNT_M0 : GNT_M1) : req;
endmodule

// File: rtl/spiram_wb_arbiter.sv
// spiram_wb_arbiter: two-master round-robin Wishbone arbiter in front of the spiram controller.
// Define SPIRAM_ARB_TIMEOUT_EN to abort stalled cycles after TIMEOUT_CYCLES and drain the owner.
module spiram_wb_arbiter
  import spiram_arb_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk48,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_dat_w,
  output logic [DATA_W-1:0]   m0_dat_r,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [2:0]          m0_cti,
  input  logic [1:0]          m0_bte,
  output logic                m0_ack,
  output logic                m0_err,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_dat_w,
  output logic [DATA_W-1:0]   m1_dat_r,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [2:0]          m1_cti,
  input  logic [1:0]          m1_bte,
  output logic                m1_ack,
  output logic                m1_err,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_w,
  input  logic [DATA_W-1:0]   s_dat_r,
  output logic [DATA_W/8-1:0] s_sel,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [2:0]          s_cti,
  output logic [1:0]          s_bte,
  input  logic                s_ack,
  input  logic                s_err,
  output logic [1:0]          grant
);
  state_t state, state_n;
  logic last_owner, last_n;
  logic [1:0] win;
  logic own0, own1, stb_raw, timeout;
  spiram_arb_rr u_rr (
    .req({m1_cyc, m0_cyc}),
    .last_owner(last_owner),
    .win(win)
  );
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign stb_raw = own0 ? m0_cyc & m0_stb : own1 ? m1_cyc & m1_stb : 1'b0;
`ifdef SPIRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk48 or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (!(own0 || own1) || s_ack || s_err) cnt <= '0;
    else if (stb_raw) cnt <= cnt + CW'(1);
  assign timeout = (own0 || own1) && cnt == CW'(TIMEOUT_CYCLES);
`else
  // a stalled slave keeps the grant forever; the limit is never reached
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    state_n = state;
    last_n = last_owner;
    case (state)
      IDLE: state_n = win[0] ? OWN0 : win[1] ? OWN1 : IDLE;
      OWN0: begin
        state_n = !m0_cyc ? IDLE : timeout ? DRAIN : OWN0;
        last_n = (!m0_cyc || timeout) ? 1'b0 : last_owner;
      end
      OWN1: begin
        state_n = !m1_cyc ? IDLE : timeout ? DRAIN : OWN1;
        last_n = (!m1_cyc || timeout) ? 1'b1 : last_owner;
      end
      default: state_n = (last_owner ? m1_cyc : m0_cyc) ? DRAIN : IDLE;
    endcase
  end
  always_ff @(posedge clk48 or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_n;
      last_owner <= last_n;
    end
  assign s_cyc = (own0 ? m0_cyc : own1 ? m1_cyc : 1'b0) & ~timeout;
  assign s_stb = stb_raw & ~timeout;
  assign s_we = own0 ? m0_we : own1 ? m1_we : 1'b0;
  assign s_adr = own0 ? m0_adr : own1 ? m1_adr : '0;
  assign s_dat_w = own0 ? m0_dat_w : own1 ? m1_dat_w : '0;
  assign s_sel = own0 ? m0_sel : own1 ? m1_sel : '0;
  assign s_cti = own0 ? m0_cti : own1 ? m1_cti : CTI_CLASSIC;
  assign s_bte = own0 ? m0_bte : own1 ? m1_bte : 2'b00;
  // responses only count while a strobe is actually presented
  assign m0_ack = own0 & s_stb & s_ack;
  assign m1_ack = own1 & s_stb & s_ack;
  assign m0_err = own0 & ((s_stb & s_err) | timeout);
  assign m1_err = own1 & ((s_stb & s_err) | timeout);
  assign m0_dat_r = own0 ? s_dat_r : '0;
  assign m1_dat_r = own1 ? s_dat_r : '0;
  assign grant = state_grant(state);
endmodule

// File: tb/tb_spiram_wb_arbiter.sv
// tb_spiram_wb_arbiter: scoreboard bench; expected grants and responses are queued at stimulus
// time and a negedge monitor pops and compares them whenever the DUT presents one.
module tb_spiram_wb_arbiter;
  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic [2:0]  cti;
  } exp_t;
  logic clk48, reset_n;
  logic [29:0] m0_adr, m1_adr, s_adr;
  logic [31:0] m0_dat_w, m1_dat_w, s_dat_w, m0_dat_r, m1_dat_r, s_dat_r;
  logic [3:0] m0_sel, m1_sel, s_sel;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_cyc, s_stb, s_we;
  logic [2:0] m0_cti, m1_cti, s_cti;
  logic [1:0] m0_bte, m1_bte, s_bte, grant;
  logic m0_ack, m0_err, m1_ack, m1_err, s_ack, s_err;
  logic slave_en;
  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] qg[$];

  spiram_wb_arbiter #(.ADDR_W(30), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk48(clk48), .reset_n(reset_n),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_sel(m0_sel),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_sel(m1_sel),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_sel(s_sel),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .grant(grant)
  );

  initial begin
    clk48 = 1'b0;
    forever #5 clk48 = ~clk48;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [31:0] dat_of(input logic [29:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk48);
    #1;
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic w,
                       input logic [29:0] a, input logic [2:0] t);
    if (m == 0) begin
      m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_dat_w = ~{2'b00, a};
      m0_sel = 4'hF; m0_cti = t; m0_bte = 2'b00;
    end else begin
      m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_dat_w = ~{2'b00, a};
      m1_sel = 4'hF; m1_cti = t; m1_bte = 2'b00;
    end
  endtask

  task automatic expect_resp(input int m, input logic err, input logic [31:0] dat,
                             input logic [2:0] cti);
    exp_t e;
    e.err = err;
    e.dat = dat;
    e.cti = cti;
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic expect_grants(input int n, input logic [1:0] first);
    logic [1:0] g;
    g = first;
    for (int i = 0; i < n; i++) begin
      qg.push_back(g);
      qg.push_back(2'b00);
      g = {g[0], g[1]};
    end
  endtask

  // Wishbone master: single (classic) or incrementing burst, one expected response per beat
  task automatic xfer(input int m, input logic [29:0] base, input logic w, input int beats);
    int done, budget;
    logic acked;
    logic [2:0] t;
    done = 0;
    budget = 0;
    t = beats > 1 ? 3'b010 : 3'b000;
    set_m(m, 1'b1, 1'b1, w, base, t);
    expect_resp(m, 1'b0, dat_of(base), t);
    while (done < beats && budget < 200) begin
      @(negedge clk48);
      budget++;
      acked = (m == 0) ? m0_ack : m1_ack;
      if (acked) done++;
      tick;
      if (done == beats) set_m(m, 1'b0, 1'b0, 1'b0, '0, 3'b000);
      else if (acked) begin
        t = done == beats - 1 ? 3'b111 : 3'b010;
        set_m(m, 1'b1, 1'b1, w, base + 30'(done), t);
        expect_resp(m, 1'b0, dat_of(base + 30'(done)), t);
      end
    end
    if (done < beats) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout m%0d: got %0d beats required %0d", m, done, beats);
      set_m(m, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    end
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk48);
    #1 reset_n = 1'b1;
    tick;
  endtask

  // slave model: acks every other strobed cycle and returns an address-derived word
  initial forever begin
    @(posedge clk48);
    #2;
    if (slave_en) begin
      s_ack = s_stb && !s_ack;
      s_err = 1'b0;
      s_dat_r = dat_of(s_adr);
    end
  end

  initial begin
    logic [1:0] prev;
    exp_t e;
    prev = 2'b00;
    forever begin
      @(negedge clk48);
      if (grant !== prev) begin
        if (qg.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected: got %b required no change from %b", grant, prev);
        end else check("grant_seq", 32'(grant), 32'(qg.pop_front()));
        prev = grant;
      end
      if (m0_ack || m0_err) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m0_unexpected: got ack=%b err=%b required none", m0_ack, m0_err);
        end else begin
          e = q0.pop_front();
          check("m0_err", 32'(m0_err), 32'(e.err));
          check("m0_dat_r", m0_dat_r, e.dat);
          check("m0_cti", 32'(s_cti), 32'(e.cti));
          check("m1_quiet", {30'd0, m1_ack, m1_err}, 32'd0);
        end
      end
      if (m1_ack || m1_err) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m1_unexpected: got ack=%b err=%b required none", m1_ack, m1_err);
        end else begin
          e = q1.pop_front();
          check("m1_err", 32'(m1_err), 32'(e.err));
          check("m1_dat_r", m1_dat_r, e.dat);
          check("m1_cti", 32'(s_cti), 32'(e.cti));
          check("m0_quiet", {30'd0, m0_ack, m0_err}, 32'd0);
        end
      end
    end
  end

  initial begin
    int found, err_seen;
    slave_en = 1'b0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_dat_r = 32'hFFFF_FFFF;
    reset_n = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b1, 30'h1234, 3'b010);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    #2 reset_n = 1'b0;
    #1;
    check("rst_s_cyc", 32'(s_cyc), 0);
    check("rst_s_stb", 32'(s_stb), 0);
    check("rst_s_we", 32'(s_we), 0);
    check("rst_s_adr", 32'(s_adr), 0);
    check("rst_s_cti", 32'(s_cti), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_m0_dat_r", m0_dat_r, 0);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    s_dat_r = 32'h0;
    repeat (2) @(posedge clk48);
    #1 reset_n = 1'b1;
    tick;

    // m0 single read, slave acks on cycle 4
    qg.push_back(2'b01);
    qg.push_back(2'b00);
    expect_resp(0, 1'b0, 32'hDEAD_BEEF, 3'b000);
    tick;
    set_m(0, 1'b1, 1'b1, 1'b0, 30'h40, 3'b000);
    @(negedge clk48);
    check("t1_c0_grant", 32'(grant), 0);
    check("t1_c0_s_cyc", 32'(s_cyc), 0);
    tick;
    @(negedge clk48);
    check("t1_c1_grant", 32'(grant), 32'h1);
    check("t1_c1_s_cyc", 32'(s_cyc), 1);
    check("t1_c1_s_adr", 32'(s_adr), 32'h40);
    repeat (3) tick;
    s_ack = 1'b1;
    s_dat_r = 32'hDEAD_BEEF;
    @(negedge clk48);
    check("t1_c4_m0_ack", 32'(m0_ack), 1);
    check("t1_c4_m1_dat_r", m1_dat_r, 0);
    tick;
    s_ack = 1'b0;
    s_dat_r = 32'h0;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    repeat (2) tick;

    // simultaneous request after reset: m0 first, then a one-cycle gap before m1
    do_reset;
    expect_grants(2, 2'b01);
    tick;
    set_m(0, 1'b1, 1'b1, 1'b0, 30'h10, 3'b000);
    set_m(1, 1'b1, 1'b1, 1'b0, 30'h20, 3'b000);
    @(negedge clk48);
    check("t2_c0_grant", 32'(grant), 0);
    tick;
    @(negedge clk48);
    check("t2_c1_grant", 32'(grant), 32'h1);
    repeat (2) tick;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    @(negedge clk48);
    check("t2_n_s_cyc", 32'(s_cyc), 0);
    @(negedge clk48);
    check("t2_n1_s_cyc", 32'(s_cyc), 0);
    check("t2_n1_grant", 32'(grant), 0);
    @(negedge clk48);
    check("t2_n2_grant", 32'(grant), 32'h2);
    check("t2_n2_s_cyc", 32'(s_cyc), 1);
    tick;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    repeat (2) tick;

    // both masters request continuously: grants alternate
    slave_en = 1'b1;
    expect_grants(8, 2'b01);
    fork
      for (int i = 0; i < 4; i++) begin
        xfer(0, 30'h100 + 30'(i), i[0], 1);
        tick;
      end
      for (int j = 0; j < 4; j++) begin
        xfer(1, 30'h200 + 30'(j), ~j[0], 1);
        tick;
      end
    join
    repeat (2) tick;

    // m1 4-beat burst keeps the grant while m0 waits
    expect_grants(2, 2'b10);
    fork
      xfer(1, 30'h300, 1'b0, 4);
      begin
        tick;
        xfer(0, 30'h400, 1'b1, 1);
      end
    join
    repeat (2) tick;
    slave_en = 1'b0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_dat_r = 32'h0;

    // asynchronous reset in the middle of an m0 write
    expect_grants(2, 2'b01);
    tick;
    set_m(0, 1'b1, 1'b1, 1'b1, 30'h77, 3'b000);
    repeat (3) tick;
    check("t5_pre_s_stb", 32'(s_stb), 1);
    #1 reset_n = 1'b0;
    #1;
    check("t5_async_s_cyc", 32'(s_cyc), 0);
    check("t5_async_grant", 32'(grant), 0);
    check("t5_async_s_we", 32'(s_we), 0);
    check("t5_async_s_adr", 32'(s_adr), 0);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    set_m(1, 1'b1, 1'b1, 1'b0, 30'h88, 3'b000);
    @(negedge clk48);
    #2 reset_n = 1'b1;
    @(posedge clk48);
    #1;
    check("t5_post_grant", 32'(grant), 32'h2);
    tick;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    repeat (2) tick;

    // stalled slave
    found = 0;
    err_seen = 0;
`ifdef SPIRAM_ARB_TIMEOUT_EN
    qg.push_back(2'b01);
    qg.push_back(2'b00);
    qg.push_back(2'b10);
    qg.push_back(2'b00);
    expect_resp(0, 1'b1, 32'h0, 3'b000);
    tick;
    set_m(0, 1'b1, 1'b1, 1'b0, 30'h55, 3'b000);
    for (int i = 1; i <= 40 && found == 0; i++) begin
      @(negedge clk48);
      if (m0_err) begin
        found = i;
        check("to_err_s_cyc", 32'(s_cyc), 0);
      end
    end
    check("to_latency", found, 17);
    @(negedge clk48);
    check("to_pulse_width", 32'(m0_err), 0);
    check("to_drain_grant", 32'(grant), 0);
    tick;
    set_m(1, 1'b1, 1'b1, 1'b0, 30'h66, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk48);
      check("to_drain_hold", 32'(grant), 0);
    end
    tick;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    for (int i = 0; i < 5 && grant != 2'b10; i++) @(negedge clk48);
    check("to_regrant", 32'(grant), 32'h2);
    tick;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, 3'b000);
`else
    qg.push_back(2'b01);
    qg.push_back(2'b00);
    tick;
    set_m(0, 1'b1, 1'b1, 1'b0, 30'h55, 3'b000);
    repeat (2000) begin
      @(negedge clk48);
      if (m0_err) err_seen++;
    end
    check("stall_grant", 32'(grant), 32'h1);
    check("stall_s_cyc", 32'(s_cyc), 1);
    check("stall_no_err", err_seen, 0);
    tick;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
`endif
    repeat (3) tick;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("qg_drained", qg.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
